// File: rtl/ball_referee.sv
`default_nettype none
// ============================================================================
// Module   : ball_referee
// Purpose  : Collision and scoring referee for the ball FSM. It infers the
//            ball's direction from successive positions, detects paddle, wall
//            and goal contacts, and holds a bounce code until the ball shows
//            (by moving) that it has consumed it. It also keeps per-side
//            scores and flags end of game.
// Ports    : clock, reset             - single clock, sync active-high reset
//            ball_x, ball_y   [9:0]   - ball top-left position
//            ball_size_x/_y   [7:0]   - ball size
//            left_y, right_y  [9:0]   - paddle top y
//            bounce           [1:0]   - 00 none, 01 paddle, 10 wall, 11 serve
//            score_left/right [3:0]   - scores
//            point_left/right         - one-cycle pulse when that side scores
//            game_over                - high once a side reaches WIN_SCORE
// Option   : REFEREE_GAME_OVER_EN - enables WIN_SCORE, saturating scores and
//            the GAME_OVER state. Undefined: scores wrap, game_over is 0.
// Revision : 1.0 - initial release
// ============================================================================
module ball_referee #(
  parameter int SCREEN_X  = 640,
  parameter int SCREEN_Y  = 480,
  parameter int PADDLE_W  = 8,
  parameter int PADDLE_H  = 64,
  parameter int LEFT_X    = 16,
  parameter int RIGHT_X   = 616,
  parameter int WIN_SCORE = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [7:0] ball_size_x,
  input  logic [7:0] ball_size_y,
  input  logic [9:0] left_y,
  input  logic [9:0] right_y,
  output logic [1:0] bounce,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       point_left,
  output logic       point_right,
  output logic       game_over
);

`ifdef REFEREE_GAME_OVER_EN
  localparam bit GAME_OVER_EN = 1'b1;
`else
  localparam bit GAME_OVER_EN = 1'b0;
`endif

  localparam logic [1:0] B_NONE   = 2'b00;
  localparam logic [1:0] B_PADDLE = 2'b01;
  localparam logic [1:0] B_WALL   = 2'b10;
  localparam logic [1:0] B_SERVE  = 2'b11;

  localparam logic [10:0] SCR_X      = 11'(SCREEN_X);
  localparam logic [10:0] WALL_HI    = 11'(SCREEN_Y - 1);
  localparam logic [10:0] LEFT_FACE  = 11'(LEFT_X + PADDLE_W);
  localparam logic [10:0] RIGHT_FACE = 11'(RIGHT_X);
  localparam logic [10:0] PAD_H      = 11'(PADDLE_H);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

  // WALL_NEXT is the single 00 cycle between a consumed paddle bounce and
  // the deferred wall bounce that coincided with it.
  typedef enum logic [2:0] {
    PLAY      = 3'd0,
    HOLD      = 3'd1,
    WALL_NEXT = 3'd2,
    SERVE     = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  state_t     state, state_d;
  logic [9:0] prev_x, prev_y;
  logic [9:0] cap_x, cap_y, cap_x_d, cap_y_d;
  logic       dir_x, dir_y, dir_x_d, dir_y_d;   // 1 = plus
  logic       dir_valid, dir_valid_d;
  logic       pending_wall, pending_wall_d;
  logic [1:0] bounce_d;
  logic [3:0] score_left_d, score_right_d;
  logic       point_left_d, point_right_d;

  // All geometry is done at 11 bits so position + size cannot overflow.
  logic [10:0] bx, by, bx_end, by_end, ly, ry;
  assign bx     = {1'b0, ball_x};
  assign by     = {1'b0, ball_y};
  assign bx_end = bx + {3'b000, ball_size_x};
  assign by_end = by + {3'b000, ball_size_y};
  assign ly     = {1'b0, left_y};
  assign ry     = {1'b0, right_y};

  logic moved, cap_moved;
  logic hit_score_left, hit_score_right, hit_left_pad, hit_right_pad, hit_wall;

  assign moved     = (ball_x != prev_x) || (ball_y != prev_y);
  assign cap_moved = (ball_x != cap_x) || (ball_y != cap_y);

  assign hit_score_right = dir_valid && !dir_x && (ball_x == 10'd0);
  assign hit_score_left  = dir_valid &&  dir_x && (bx_end >= SCR_X);
  assign hit_left_pad    = dir_valid && !dir_x && (bx == LEFT_FACE) &&
                           (by_end > ly) && (by < ly + PAD_H);
  assign hit_right_pad   = dir_valid &&  dir_x && (bx_end == RIGHT_FACE) &&
                           (by_end > ry) && (by < ry + PAD_H);
  // One-pixel margin so a wall bounce deferred behind a paddle bounce is
  // still recognised after the ball has taken one more step.
  assign hit_wall        = dir_valid &&
                           ((!dir_y && (by <= 11'd1)) || (dir_y && (by_end >= WALL_HI)));

  function automatic logic [3:0] bump(input logic [3:0] s);
    if (GAME_OVER_EN && (s >= WIN)) return s;
    return s + 4'd1;
  endfunction

  always_comb begin
    state_d        = state;
    bounce_d       = bounce;
    cap_x_d        = cap_x;
    cap_y_d        = cap_y;
    pending_wall_d = pending_wall;
    score_left_d   = score_left;
    score_right_d  = score_right;
    point_left_d   = 1'b0;
    point_right_d  = 1'b0;
    dir_x_d        = dir_x;
    dir_y_d        = dir_y;
    dir_valid_d    = dir_valid;

    // Direction tracking runs in every state; an axis with no delta keeps
    // its last known sign.
    if (ball_x != prev_x) dir_x_d = (ball_x > prev_x);
    if (ball_y != prev_y) dir_y_d = (ball_y > prev_y);
    if (moved)            dir_valid_d = 1'b1;

    case (state)
      PLAY: begin
        bounce_d = B_NONE;
        if (hit_score_left || hit_score_right) begin
          if (hit_score_left) begin
            score_left_d = bump(score_left);
            point_left_d = 1'b1;
          end else begin
            score_right_d = bump(score_right);
            point_right_d = 1'b1;
          end
          bounce_d    = B_SERVE;
          cap_x_d     = ball_x;
          cap_y_d     = ball_y;
          dir_valid_d = 1'b0;
          state_d     = SERVE;
        end else if (hit_left_pad || hit_right_pad) begin
          bounce_d       = B_PADDLE;
          pending_wall_d = hit_wall;
          cap_x_d        = ball_x;
          cap_y_d        = ball_y;
          state_d        = HOLD;
        end else if (hit_wall) begin
          bounce_d = B_WALL;
          cap_x_d  = ball_x;
          cap_y_d  = ball_y;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (cap_moved) begin
          bounce_d       = B_NONE;
          pending_wall_d = 1'b0;
          state_d        = pending_wall ? WALL_NEXT : PLAY;
        end
      end
      WALL_NEXT: begin
        bounce_d = B_WALL;
        cap_x_d  = ball_x;
        cap_y_d  = ball_y;
        state_d  = HOLD;
      end
      SERVE: begin
        // The recentring jump says nothing about the next rally's direction.
        dir_valid_d = 1'b0;
        bounce_d    = B_SERVE;
        if (cap_moved) begin
          if (GAME_OVER_EN && ((score_left >= WIN) || (score_right >= WIN))) begin
            state_d = GAME_OVER;
          end else begin
            bounce_d = B_NONE;
            state_d  = PLAY;
          end
        end
      end
      GAME_OVER: begin
        dir_valid_d = 1'b0;
        bounce_d    = B_SERVE;
      end
      default: begin
        bounce_d = B_NONE;
        state_d  = PLAY;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= PLAY;
      bounce       <= B_NONE;
      cap_x        <= '0;
      cap_y        <= '0;
      pending_wall <= 1'b0;
      score_left   <= '0;
      score_right  <= '0;
      point_left   <= 1'b0;
      point_right  <= 1'b0;
      dir_x        <= 1'b0;
      dir_y        <= 1'b0;
      dir_valid    <= 1'b0;
    end else begin
      state        <= state_d;
      bounce       <= bounce_d;
      cap_x        <= cap_x_d;
      cap_y        <= cap_y_d;
      pending_wall <= pending_wall_d;
      score_left   <= score_left_d;
      score_right  <= score_right_d;
      point_left   <= point_left_d;
      point_right  <= point_right_d;
      dir_x        <= dir_x_d;
      dir_y        <= dir_y_d;
      dir_valid    <= dir_valid_d;
    end
  end

  // Previous position follows the inputs every edge, reset included, so the
  // first cycle after reset never sees a spurious move.
  always_ff @(posedge clock) begin
    prev_x <= ball_x;
    prev_y <= ball_y;
  end

`ifdef REFEREE_GAME_OVER_EN
  assign game_over = (state == GAME_OVER);
`else
  assign game_over = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ball_referee.sv
`default_nettype none
// ============================================================================
// Module   : tb_ball_referee
// Purpose  : Self-checking bench for ball_referee: a table of per-cycle
//            vectors for wall, paddle and goal events, plus hand-written
//            sequences for the paddle+wall corner, reset mid-HOLD and the
//            score limit (wrap, or game over with REFEREE_GAME_OVER_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ball_referee;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] ball_x, ball_y, left_y, right_y;
  logic [7:0] ball_size_x, ball_size_y;
  logic [1:0] bounce;
  logic [3:0] score_left, score_right;
  logic       point_left, point_right, game_over;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ball_referee dut (
    .clock      (clock),
    .reset      (reset),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .ball_size_x(ball_size_x),
    .ball_size_y(ball_size_y),
    .left_y     (left_y),
    .right_y    (right_y),
    .bounce     (bounce),
    .score_left (score_left),
    .score_right(score_right),
    .point_left (point_left),
    .point_right(point_right),
    .game_over  (game_over)
  );

  typedef struct {
    logic       rst;
    logic [9:0] x, y, ly, ry;
    logic [1:0] b;
    logic [3:0] sl, sr;
    logic       pl, pr;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int b, input int sl, input int sr,
                         input int pl, input int pr, input int go);
    chk({tag, " bounce"},      int'(bounce),      b);
    chk({tag, " score_left"},  int'(score_left),  sl);
    chk({tag, " score_right"}, int'(score_right), sr);
    chk({tag, " point_left"},  int'(point_left),  pl);
    chk({tag, " point_right"}, int'(point_right), pr);
    chk({tag, " game_over"},   int'(game_over),   go);
  endtask

  task automatic drive(input int x, input int y);
    ball_x = 10'(x);
    ball_y = 10'(y);
  endtask

  initial begin
    // rst, x, y, left_y, right_y | bounce, score_l, score_r, point_l, point_r
    vecs[0]  = '{1'b1, 10'd320, 10'd240, 10'd200, 10'd200, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 10'd320, 10'd240, 10'd200, 10'd200, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 10'd322, 10'd242, 10'd200, 10'd200, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 10'd322, 10'd242, 10'd200, 10'd200, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 10'd322, 10'd471, 10'd200, 10'd200, 2'd2, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 10'd322, 10'd471, 10'd200, 10'd200, 2'd2, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 10'd322, 10'd471, 10'd200, 10'd200, 2'd2, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 10'd324, 10'd469, 10'd200, 10'd200, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 10'd324, 10'd469, 10'd200, 10'd200, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 10'd600, 10'd230, 10'd200, 10'd200, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 10'd608, 10'd230, 10'd200, 10'd200, 2'd1, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 10'd608, 10'd230, 10'd200, 10'd200, 2'd1, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 10'd606, 10'd228, 10'd200, 10'd200, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 10'd606, 10'd228, 10'd200, 10'd200, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 10'd620, 10'd240, 10'd200, 10'd0,   2'd0, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 10'd632, 10'd240, 10'd200, 10'd0,   2'd3, 4'd1, 4'd0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 10'd632, 10'd240, 10'd200, 10'd0,   2'd3, 4'd1, 4'd0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 10'd632, 10'd240, 10'd200, 10'd0,   2'd3, 4'd1, 4'd0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 10'd320, 10'd240, 10'd200, 10'd0,   2'd0, 4'd1, 4'd0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 10'd320, 10'd240, 10'd200, 10'd0,   2'd0, 4'd1, 4'd0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 10'd100, 10'd240, 10'd200, 10'd200, 2'd0, 4'd1, 4'd0, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 10'd0,   10'd240, 10'd200, 10'd200, 2'd3, 4'd1, 4'd1, 1'b0, 1'b1};
    vecs[22] = '{1'b0, 10'd0,   10'd240, 10'd200, 10'd200, 2'd3, 4'd1, 4'd1, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 10'd320, 10'd240, 10'd200, 10'd200, 2'd0, 4'd1, 4'd1, 1'b0, 1'b0};

    ball_size_x = 8'd8;
    ball_size_y = 8'd8;
    reset   = 1'b1;
    left_y  = 10'd200;
    right_y = 10'd200;
    drive(320, 240);

    // Table: wall, right paddle, left-side point, right-side point.
    for (int i = 0; i < NV; i++) begin
      reset   = vecs[i].rst;
      ball_x  = vecs[i].x;
      ball_y  = vecs[i].y;
      left_y  = vecs[i].ly;
      right_y = vecs[i].ry;
      tick();
      chk_all($sformatf("vec%0d", i), int'(vecs[i].b), int'(vecs[i].sl), int'(vecs[i].sr),
              int'(vecs[i].pl), int'(vecs[i].pr), 0);
    end

    // Corner: paddle and wall together -> 01, one 00 cycle, then 10.
    left_y = 10'd0;
    drive(40, 20);  tick(); chk("corner approach", int'(bounce), 0);
    drive(24, 1);   tick(); chk("corner paddle",   int'(bounce), 1);
                    tick(); chk("corner held",     int'(bounce), 1);
    drive(26, 0);   tick(); chk("corner gap",      int'(bounce), 0);
                    tick(); chk("corner wall",     int'(bounce), 2);
                    tick(); chk("corner wall held", int'(bounce), 2);
    drive(28, 1);   tick(); chk("corner done",     int'(bounce), 0);
                    tick(); chk("corner idle",     int'(bounce), 0);

    // Reset while a wall bounce is held.
    left_y = 10'd200;
    drive(100, 300); tick(); chk("rst approach", int'(bounce), 0);
    drive(102, 471); tick(); chk("rst wall",     int'(bounce), 2);
    reset = 1'b1;    tick(); chk_all("rst abort", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;    tick(); chk("rst no move 1", int'(bounce), 0);
                     tick(); chk("rst no move 2", int'(bounce), 0);
    drive(102, 472); tick(); chk("rst first move", int'(bounce), 0);
                     tick(); chk("rst wall again", int'(bounce), 2);
    drive(320, 240); tick(); chk("rst consume",    int'(bounce), 0);

    // Score limit: repeated left points.
`ifdef REFEREE_GAME_OVER_EN
    for (int k = 1; k <= 9; k++) begin
      drive(330, 240); tick();
      drive(632, 240); tick();
      chk_all($sformatf("pt%0d hit", k), 3, k, 0, 1, 0, 0);
      tick();
      chk_all($sformatf("pt%0d serve", k), 3, k, 0, 0, 0, 0);
      drive(320, 240); tick();
      if (k < 9) chk_all($sformatf("pt%0d play", k), 0, k, 0, 0, 0, 0);
      else       chk_all("game over entry", 3, 9, 0, 0, 0, 1);
    end
    drive(330, 240); tick();
    drive(632, 240); tick();
    chk_all("game over frozen", 3, 9, 0, 0, 0, 1);
`else
    for (int k = 1; k <= 16; k++) begin
      drive(330, 240); tick();
      drive(632, 240); tick();
      chk_all($sformatf("pt%0d hit", k), 3, k % 16, 0, 1, 0, 0);
      tick();
      chk_all($sformatf("pt%0d serve", k), 3, k % 16, 0, 0, 0, 0);
      drive(320, 240); tick();
      chk_all($sformatf("pt%0d play", k), 0, k % 16, 0, 0, 0, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
